// File: rtl/parametric_uart.sv
// parametric_uart: single-clock UART, programmable 16x tick, valid/ready TX, FWFT RX FIFO, sticky errors.
// Optional parity bit when UART_PARITY_EN is defined (sense chosen by PARITY_ODD).
module parametric_uart #(
  parameter int DATA_BITS = 8,
  parameter int DIVISOR_WIDTH = 16,
  parameter int STOP_BITS = 1,
  parameter int RX_FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [DIVISOR_WIDTH-1:0] Divisor,
  input  logic [DATA_BITS-1:0]     TxData,
  input  logic                     TxValid,
  output logic                     TxReady,
  output logic                     TxBusy,
  output logic                     Tx,
  input  logic                     Rx,
  output logic [DATA_BITS-1:0]     RxData,
  output logic                     RxValid,
  input  logic                     RxReady,
  output logic [2:0]               Errors,
  input  logic                     ErrorClear
);
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
`ifdef UART_PARITY_EN
  localparam logic ODD = 1'(PARITY_ODD);
`endif
  if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) || PARITY_ODD < 0 ||
      PARITY_ODD > 1 || RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("parametric_uart: unsupported parameter set");
  end
  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP, RX_BREAK
  } rx_state_t;
  // Divisor is captured only on reload so a mid-period change never shortens a tick
  logic [DIVISOR_WIDTH-1:0] tick_cnt, div_q;
  logic tick;
  assign tick = tick_cnt == div_q;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      tick_cnt <= '0;
      div_q <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
      div_q <= Divisor;
    end else
      tick_cnt <= tick_cnt + 1'b1;
  tx_state_t tx_state, tx_next;
  logic [3:0] tx_tick, tx_tick_n, tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
  logic tx_end;
`ifdef UART_PARITY_EN
  logic tx_par, tx_par_n;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) tx_par <= 1'b0;
    else tx_par <= tx_par_n;
  assign Tx = tx_state == TX_START ? 1'b0 : tx_state == TX_DATA ? tx_sh[0] : tx_state == TX_PARITY ? tx_par : 1'b1;
`else
  assign Tx = tx_state == TX_START ? 1'b0 : tx_state == TX_DATA ? tx_sh[0] : 1'b1;
`endif
  assign TxReady = tx_state == TX_IDLE;
  assign TxBusy = tx_state != TX_IDLE;
  assign tx_end = tick && tx_tick == 4'd15;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      tx_state <= TX_IDLE;
      tx_tick <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
    end else begin
      tx_state <= tx_next;
      tx_tick <= tx_tick_n;
      tx_bit <= tx_bit_n;
      tx_sh <= tx_sh_n;
    end
  always_comb begin
    tx_next = tx_state;
    tx_tick_n = tick ? tx_tick + 4'd1 : tx_tick;
    tx_bit_n = tx_bit;
    tx_sh_n = tx_sh;
`ifdef UART_PARITY_EN
    tx_par_n = tx_par;
`endif
    case (tx_state)
      TX_IDLE: begin
        tx_tick_n = '0;
        tx_bit_n = '0;
        if (TxValid) begin
          tx_next = TX_START;
          tx_sh_n = TxData;
`ifdef UART_PARITY_EN
          tx_par_n = ^TxData ^ ODD;
`endif
        end
      end
      TX_START: tx_next = tx_end ? TX_DATA : tx_state;
      TX_DATA: if (tx_end) begin
        tx_sh_n = tx_sh >> 1;
        tx_bit_n = tx_bit == LAST_DATA ? 4'd0 : tx_bit + 4'd1;
`ifdef UART_PARITY_EN
        tx_next = tx_bit == LAST_DATA ? TX_PARITY : tx_state;
`else
        tx_next = tx_bit == LAST_DATA ? TX_STOP : tx_state;
`endif
      end
`ifdef UART_PARITY_EN
      TX_PARITY: tx_next = tx_end ? TX_STOP : tx_state;
`endif
      TX_STOP: if (tx_end) begin
        tx_bit_n = tx_bit + 4'd1;
        tx_next = tx_bit == LAST_STOP ? TX_IDLE : tx_state;
      end
      default: tx_next = TX_IDLE;
    endcase
  end
  logic [1:0] sync;
  logic rx_s;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) sync <= 2'b11;
    else sync <= {sync[0], Rx};
  assign rx_s = sync[1];
  rx_state_t rx_state, rx_next;
  logic [3:0] rx_tick, rx_tick_n, rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_sh, rx_sh_n;
  logic rx_mid, rx_end, push, frame_err, par_err;
  assign rx_mid = tick && rx_tick == 4'd7;
  assign rx_end = tick && rx_tick == 4'd15;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      rx_state <= RX_IDLE;
      rx_tick <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
    end else begin
      rx_state <= rx_next;
      rx_tick <= rx_tick_n;
      rx_bit <= rx_bit_n;
      rx_sh <= rx_sh_n;
    end
  // START realigns the tick count at mid-bit so every later sample lands mid-bit
  always_comb begin
    rx_next = rx_state;
    rx_tick_n = tick ? rx_tick + 4'd1 : rx_tick;
    rx_bit_n = rx_bit;
    rx_sh_n = rx_sh;
    push = 1'b0;
    frame_err = 1'b0;
    par_err = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_tick_n = '0;
        rx_bit_n = '0;
        rx_next = rx_s ? RX_IDLE : RX_START;
      end
      RX_START: if (rx_mid) begin
        rx_tick_n = '0;
        rx_next = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_end) begin
        rx_sh_n = {rx_s, rx_sh[DATA_BITS-1:1]};
        rx_bit_n = rx_bit + 4'd1;
`ifdef UART_PARITY_EN
        rx_next = rx_bit == LAST_DATA ? RX_PARITY : rx_state;
`else
        rx_next = rx_bit == LAST_DATA ? RX_STOP : rx_state;
`endif
      end
`ifdef UART_PARITY_EN
      RX_PARITY: if (rx_end) begin
        par_err = rx_s != (^rx_sh ^ ODD);
        rx_next = RX_STOP;
      end
`endif
      RX_STOP: if (rx_end) begin
        push = 1'b1;
        frame_err = !rx_s;
        rx_next = rx_s ? RX_IDLE : RX_BREAK;
      end
      RX_BREAK: rx_next = rx_s ? RX_IDLE : rx_state;
      default: rx_next = RX_IDLE;
    endcase
  end
  logic [DATA_BITS-1:0] mem [RX_FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic full, pop, wr, overrun;
  assign full = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
  assign RxValid = wptr != rptr;
  assign pop = RxValid && RxReady;
  assign wr = push && (!full || pop);
  assign overrun = push && full && !pop;
  assign RxData = RxValid ? mem[rptr[AW-1:0]] : '0;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wr ? wptr + 1'b1 : wptr;
      rptr <= pop ? rptr + 1'b1 : rptr;
    end
  always_ff @(posedge Clock)
    if (wr) mem[wptr[AW-1:0]] <= rx_sh;
  // set wins over clear so an error in the clear clock is never lost
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) Errors <= '0;
    else Errors <= (ErrorClear ? 3'b000 : Errors) | {overrun, par_err, frame_err};
endmodule

// File: tb/tb_parametric_uart.sv
// tb_parametric_uart: directed vectors for parametric_uart (8 data bits, 1 stop, 4-deep FIFO).
module tb_parametric_uart;
`ifdef UART_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 10 + PAR;
  logic clk = 0, rst = 1, tx_valid = 0, tx_ready, tx_busy, tx, rx, rx_drv = 1, loop = 0;
  logic rx_valid, rx_ready = 0, error_clear = 0;
  logic [15:0] divisor = 0;
  logic [7:0] tx_data = 0, rx_data;
  logic [2:0] errors;
  int vectors = 0, miscompares = 0;
  logic [7:0] got [$];
  assign rx = loop ? tx : rx_drv;
  always #5 clk = ~clk;
  parametric_uart dut (
    .Clock(clk), .Reset(rst), .Divisor(divisor), .TxData(tx_data), .TxValid(tx_valid),
    .TxReady(tx_ready), .TxBusy(tx_busy), .Tx(tx), .Rx(rx), .RxData(rx_data),
    .RxValid(rx_valid), .RxReady(rx_ready), .Errors(errors), .ErrorClear(error_clear)
  );
  always begin
    @(negedge clk);
    #2;
    if (!rst && rx_valid && rx_ready) got.push_back(rx_data);
  end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask
  task automatic gap(input int n);
    rx_drv = 1;
    repeat (n) @(negedge clk);
  endtask
  task automatic rx_frame(input logic [7:0] d, input logic stop, input logic par, input int pop_at);
    logic [10:0] b;
    b = '1;
    b[0] = 1'b0;
    b[8:1] = d;
    if (PAR == 1) b[9] = par;
    b[NB-1] = stop;
    for (int i = 0; i < NB * 16; i++) begin
      rx_drv = b[i/16];
      if (pop_at >= 0) rx_ready = i == pop_at;
      @(negedge clk);
    end
    if (pop_at >= 0) rx_ready = 0;
  endtask
  task automatic tx_send(input logic [7:0] d);
    for (int n = 0; n < 4000 && !tx_ready; n++) @(negedge clk);
    check("tx_ready_wait", tx_ready, 1);
    tx_data = d;
    tx_valid = 1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 0;
  endtask
  task automatic clear_errors;
    error_clear = 1;
    @(negedge clk);
    error_clear = 0;
    check("err_clear", errors, 3'b000);
  endtask
  task automatic drain(input int n);
    rx_ready = 1;
    repeat (n) @(negedge clk);
    rx_ready = 0;
  endtask
  initial begin
    logic [10:0] fr;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_errors", errors, 0);
    rst = 0;
    @(negedge clk);
    // TX waveform at Divisor=0: 16 clocks per bit, checked mid-bit
    fr = '1;
    fr[0] = 1'b0;
    fr[8:1] = 8'hA5;
    if (PAR == 1) fr[9] = ^8'hA5;
    tx_data = 8'hA5;
    tx_valid = 1;
    @(posedge clk);
    @(negedge clk);
    tx_data = 8'h3C;
    for (int i = 0; i < NB * 16; i++) begin
      if (i % 16 == 8) check($sformatf("tx_bit%0d", i / 16), tx, fr[i/16]);
      if (i == NB * 16 - 1) check("tx_busy_last", {tx_ready, tx_busy}, 2'b01);
      @(negedge clk);
    end
    check("tx_ready_back", {tx_ready, tx}, 2'b11);
    @(negedge clk);
    check("tx_next_start", {tx_busy, tx}, 2'b10);
    tx_valid = 0;
    for (int n = 0; n < 4000 && !tx_ready; n++) @(negedge clk);
    check("tx_idle_wait", tx_ready, 1);
    // loopback at Divisor=3
    divisor = 3;
    loop = 1;
    rx_ready = 1;
    got.delete();
    repeat (8) @(negedge clk);
    tx_send(8'h00);
    tx_send(8'hFF);
    tx_send(8'h5A);
    for (int n = 0; n < 3000 && got.size() < 3; n++) @(negedge clk);
    check("loop_count", got.size(), 3);
    if (got.size() == 3) begin
      check("loop_w0", got[0], 8'h00);
      check("loop_w1", got[1], 8'hFF);
      check("loop_w2", got[2], 8'h5A);
    end
    check("loop_errors", errors, 0);
    loop = 0;
    rx_ready = 0;
    divisor = 0;
    got.delete();
    gap(20);
    // false start: 5-clock low pulse
    rx_drv = 0;
    repeat (5) @(negedge clk);
    gap(40);
    check("false_start_valid", rx_valid, 0);
    check("false_start_err", errors, 0);
    // framing error followed by a long break
    rx_frame(8'h81, 1'b0, ^8'h81, -1);
    repeat (100) @(negedge clk);
    gap(40);
    check("frame_valid", rx_valid, 1);
    check("frame_data", rx_data, 8'h81);
    check("frame_err", errors, 3'b001);
    drain(6);
    check("break_words", got.size(), 1);
    clear_errors();
    // overrun: five frames into a 4-deep FIFO with no pops
    got.delete();
    for (int k = 1; k <= 5; k++) begin
      rx_frame(8'(k), 1'b1, ^(8'(k)), -1);
      gap(4);
    end
    check("ovr_err", errors, 3'b100);
    check("ovr_head", {rx_valid, rx_data}, {1'b1, 8'h01});
    drain(8);
    check("ovr_count", got.size(), 4);
    for (int k = 0; k < 4 && k < got.size(); k++) check($sformatf("ovr_w%0d", k), got[k], k + 1);
    clear_errors();
    // pop coincides with the fifth push into a full FIFO
    got.delete();
    for (int k = 1; k <= 4; k++) begin
      rx_frame(8'(k), 1'b1, ^(8'(k)), -1);
      gap(4);
    end
    rx_frame(8'h05, 1'b1, ^8'h05, 16 * (NB - 1) + 10);
    gap(4);
    check("same_clk_err", errors, 3'b000);
    check("same_clk_popped", got.size(), 1);
    drain(8);
    check("same_clk_count", got.size(), 5);
    for (int k = 0; k < 5 && k < got.size(); k++) check($sformatf("same_clk_w%0d", k), got[k], k + 1);
`ifdef UART_PARITY_EN
    rx_frame(8'h07, 1'b1, 1'b0, -1);
    gap(4);
    check("par_err", errors, 3'b010);
    check("par_data", rx_data, 8'h07);
    drain(4);
    clear_errors();
`endif
    // reset in the middle of a TX data bit with a word waiting in the FIFO
    rx_frame(8'h42, 1'b1, ^8'h42, -1);
    gap(4);
    check("pre_rst_valid", rx_valid, 1);
    tx_send(8'h99);
    repeat (40) @(negedge clk);
    check("pre_rst_busy", tx_busy, 1);
    rst = 1;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_ready", tx_ready, 1);
    check("mid_rst_busy", tx_busy, 0);
    check("mid_rst_rx_valid", rx_valid, 0);
    @(negedge clk);
    rst = 0;
    repeat (4) @(negedge clk);
    check("post_rst_rx_valid", rx_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/parametric_uart.md
Name: parametric_uart

Overview:
Single-clock UART with a programmable baud divisor, a 16x-oversampled receiver, and a valid/ready transmit interface. It adds a receive FIFO and sticky error reporting, and is parametrised in data width, stop bits and FIFO depth. It replaces the fixed-rate multi-clock UART in the UART application; all logic runs on Clock, and baud timing comes from a clock-enable tick, not a derived clock.

Parameters:
DATA_BITS, 8, data bits per frame (5..9)
DIVISOR_WIDTH, 16, width of the Divisor input
STOP_BITS, 1, stop bits transmitted and checked (1 or 2)
RX_FIFO_DEPTH, 4, receive FIFO entries (power of 2, >=2)
PARITY_ODD, 0, parity sense when UART_PARITY_EN is defined (0 even, 1 odd)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Divisor  in  DIVISOR_WIDTH  oversample tick period minus 1, in clocks
TxData  in  DATA_BITS  word to send
TxValid  in  1  TxData valid
TxReady  out  1  transmitter can accept a word
TxBusy  out  1  frame in progress
Tx  out  1  serial output, idle high
Rx  in  1  serial input, asynchronous
RxData  out  DATA_BITS  head of receive FIFO
RxValid  out  1  FIFO non-empty
RxReady  in  1  pop FIFO head
Errors  out  3  sticky flags: [0] framing, [1] parity, [2] overrun
ErrorClear  in  1  clears Errors

Behaviour:
- Reset values: Tx=1, TxReady=1, TxBusy=0, RxValid=0, RxData=0, Errors=0. The FIFO is emptied and both FSMs go to IDLE. Reset mid-frame aborts the frame immediately; no partial word is stored.
- Tick generator: the counter runs 0..Divisor, pulses Tick for one clock at Divisor, then reloads 0. Divisor=0 gives Tick every clock. A Divisor change takes effect after the next reload. One bit lasts 16 ticks.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - In IDLE, TxReady=1. A handshake is TxValid&&TxReady on a rising edge. It latches TxData and enters START, with Tx=0 from the next clock.
  - Each bit is held 16 ticks. Data is sent LSB first, DATA_BITS bits. PARITY is present only with the macro.
  - STOP holds Tx=1 for STOP_BITS*16 ticks, then returns to IDLE.
  - TxReady=0 and TxBusy=1 everywhere outside IDLE.
  - If TxValid is held, the next frame starts the clock after STOP ends, with no extra idle.
- RX synchroniser: 2-flop synchroniser on Rx, both flops reset to 1.
- RX FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE to START when the synchronised Rx is 0.
  - START samples at tick 8. If Rx=1, the start is false: return to IDLE with no flag.
  - After a valid start, sample every 16 ticks at mid-bit, LSB first, into a shift register.
  - STOP samples the first stop bit only. If it is 0, set Errors[0] and still push the word, then go to BREAK. BREAK waits for Rx=1, then goes to IDLE.
  - If the stop bit is 1, return to IDLE right after the sample, ready for an immediate next start.
- Push: occurs in the clock of the stop sample.
  - FIFO full and no pop in that clock: the word is dropped, Errors[2] is set, and the FIFO is unchanged.
  - FIFO full with a pop in the same clock: both happen, and no overrun is flagged.
- FIFO: first-word-fall-through. RxData shows the head while RxValid=1. A pop is RxValid&&RxReady. Pointers wrap modulo RX_FIFO_DEPTH and use an extra MSB for full/empty. RxReady while empty is ignored.
- Errors: each flag is set-only and stays until an ErrorClear clock. If ErrorClear and a new error occur in the same clock, the flag ends up set.

Optional Feature:
UART_PARITY_EN
- Defined: TX inserts a parity bit after the data (even parity, or odd if PARITY_ODD=1). RX samples it in PARITY, and a mismatch sets Errors[1]; the word is still pushed.
- Undefined: there is no PARITY state, the frame is 1+DATA_BITS+STOP_BITS bits, and Errors[1] is tied 0.

Test Plan:
- Divisor=0, 8N1, send 0xA5: Tx=0 for 16 clocks, then bits 1,0,1,0,0,1,0,1 at 16 clocks each, then stop=1. TxReady returns high 160 clocks after the handshake. TxValid held with 0x3C queued: its start bit follows immediately.
- Loopback Tx->Rx, Divisor=3, send 0x00, 0xFF, 0x5A with RxReady=1: RxData gives 0x00, 0xFF, 0x5A in order, Errors=0.
- Rx low pulse of 5 ticks, Divisor=0: no RxValid, Errors=0, RX back in IDLE.
- Frame with stop bit driven 0, data 0x81: RxData=0x81, RxValid=1, Errors=3'b001. Rx held low 100 ticks then high: no extra word. ErrorClear pulse gives Errors=0.
- RX_FIFO_DEPTH=4, RxReady=0, five frames 0x01..0x05: four words 0x01..0x04 are poppable and Errors[2]=1. Repeat with a pop in the same clock as the 5th push: no overrun, 0x05 is retained.
- UART_PARITY_EN defined, even parity, 0x07 sent with parity bit forced 0: Errors[1]=1 and RxData=0x07. Reset asserted mid-data bit: Tx=1, RxValid=0, and TxReady=1 immediately.
